mem_bus_arbiter: RTL and testbench

//  Shares one memory port between the core's instruction-fetch requester and data (load/store) requester.

---
 rtl/mem_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares a single memory port between the instruction-fetch requester and the
// data (load/store) requester.
//
// Arbitration alternates when both sides are requesting, and the first contested grant after
// reset goes to data. Each grant runs one m_req/m_ack handshake. The read data is registered
// into rdata_o, and the owner receives a one-cycle done pulse. If memory does not acknowledge
// within TIMEOUT_CYCLES busy cycles, the transfer is aborted and a sticky bus error is raised.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   if_req_i, if_addr_i           fetch request (held until if_done_o) and its address
//   if_done_o                     1-cycle pulse: fetch complete, rdata_o valid
//   d_req_i, d_we_i, d_addr_i,    data request (held until d_done_o), 1 = store, address,
//   d_wdata_i, d_be_i             store data and byte enables
//   d_done_o                      1-cycle pulse: data transfer complete, rdata_o valid
//   rdata_o                       read data of the last completed load/fetch
//   stall_o                       combinational stall to the control unit
//   bus_error_o                   sticky timeout flag, cleared only by reset
//   m_req_o, m_we_o, m_addr_o,    registered memory request, write enable, address,
//   m_wdata_o, m_be_o             write data and byte enables
//   m_ack_i, m_rdata_i            memory acknowledge and read data
module mem_bus_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_done_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  input  logic [DW/8-1:0] d_be_i,
  output logic            d_done_o,
  output logic [DW-1:0]   rdata_o,
  output logic            stall_o,
  output logic            bus_error_o,
  output logic            m_req_o,
  output logic            m_we_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [DW-1:0]   m_wdata_o,
  output logic [DW/8-1:0] m_be_o,
  input  logic            m_ack_i,
  input  logic [DW-1:0]   m_rdata_i
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Last busy-cycle count before abort; only meaningful when the timeout is enabled.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic {OwnIf, OwnData} owner_e;

  state_e          state_q, state_d;
  owner_e          last_owner_q, last_owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [BW-1:0]   m_be_q, m_be_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic            bus_error_q, bus_error_d;
  logic            grant_data;

  // Data wins if it is alone, or if both are requesting and fetch held the port last time.
  assign grant_data = d_req_i && (!if_req_i || (last_owner_q == OwnIf));

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_be_d       = m_be_q;
    rdata_d      = rdata_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    bus_error_d  = bus_error_q;

    unique case (state_q)
      StIdle: begin
        if (if_req_i || d_req_i) begin
          m_req_d = 1'b1;
          state_d = StBusy;
          if (grant_data) begin
            last_owner_d = OwnData;
            m_we_d       = d_we_i;
            m_addr_d     = d_addr_i;
            m_wdata_d    = d_wdata_i;
            m_be_d       = d_be_i;
          end else begin
            last_owner_d = OwnIf;
            m_we_d       = 1'b0;
            m_addr_d     = if_addr_i;
            m_wdata_d    = '0;
            m_be_d       = '1;
          end
        end
      end

      StBusy: begin
        if (m_ack_i) begin
          // Stores leave the last read value in place.
          if (!m_we_q) begin
            rdata_d = m_rdata_i;
          end
          m_req_d = 1'b0;
          state_d = StDone;
          if (last_owner_q == OwnData) begin
            d_done_d = 1'b1;
          end else begin
            if_done_d = 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
          // Abort: complete the transfer towards the requester, but with zero data.
          m_req_d     = 1'b0;
          bus_error_d = 1'b1;
          rdata_d     = '0;
          state_d     = StDone;
          if (last_owner_q == OwnData) begin
            d_done_d = 1'b1;
          end else begin
            if_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_owner_q <= OwnIf;
      cnt_q        <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
      rdata_q      <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_be_q       <= m_be_d;
      rdata_q      <= rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign if_done_o   = if_done_q;
  assign d_done_o    = d_done_q;
  assign rdata_o     = rdata_q;
  assign bus_error_o = bus_error_q;
  assign m_req_o     = m_req_q;
  assign m_we_o      = m_we_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign m_be_o      = m_be_q;
  assign stall_o     = (if_req_i && !if_done_q) || (d_req_i && !d_done_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (timeout set to 8 busy cycles).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_be;
  logic          d_done;
  logic [31:0]   rdata;
  logic          stall;
  logic          bus_error;
  logic          m_req;
  logic          m_we;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_be;
  logic          m_ack;
  logic [31:0]   m_rdata;

  int unsigned   vectors;
  int unsigned   miscompares;
  logic [31:0]   exp_rdata;
  logic          own_d;

  mem_bus_arbiter #(
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_done_o   (if_done),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_be_i      (d_be),
    .d_done_o    (d_done),
    .rdata_o     (rdata),
    .stall_o     (stall),
    .bus_error_o (bus_error),
    .m_req_o     (m_req),
    .m_we_o      (m_we),
    .m_addr_o    (m_addr),
    .m_wdata_o   (m_wdata),
    .m_be_o      (m_be),
    .m_ack_i     (m_ack),
    .m_rdata_i   (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = '0;
    m_ack   = 1'b0;
    m_rdata = '0;

    // Reset state
    step();
    step();
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_m_we", m_we, 1'b0);
    chk32("rst_m_addr", m_addr, 32'h0);
    chk32("rst_m_wdata", m_wdata, 32'h0);
    chk32("rst_m_be", 32'(m_be), 32'h0);
    chk32("rst_rdata", rdata, 32'h0);
    chk1("rst_if_done", if_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk1("rst_bus_error", bus_error, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    rst = 1'b1;
    step();

    // 1: zero-wait fetch
    if_req  = 1'b1;
    if_addr = 32'h100;
    #1;
    chk1("t1_stall_idle", stall, 1'b1);
    step();
    chk1("t1_m_req", m_req, 1'b1);
    chk32("t1_m_addr", m_addr, 32'h100);
    chk1("t1_m_we", m_we, 1'b0);
    chk32("t1_m_be", 32'(m_be), 32'hf);
    chk32("t1_m_wdata", m_wdata, 32'h0);
    chk1("t1_if_done_early", if_done, 1'b0);
    m_ack   = 1'b1;
    m_rdata = 32'h0050_0093;
    step();
    chk1("t1_if_done", if_done, 1'b1);
    chk1("t1_d_done", d_done, 1'b0);
    chk32("t1_rdata", rdata, 32'h0050_0093);
    chk1("t1_stall_done", stall, 1'b0);
    chk1("t1_m_req_drop", m_req, 1'b0);
    if_req = 1'b0;
    m_ack  = 1'b0;
    step();
    chk1("t1_if_done_pulse", if_done, 1'b0);
    // ack while idle must be ignored
    m_ack   = 1'b1;
    m_rdata = 32'hffff_ffff;
    step();
    step();
    chk32("t1_idle_ack_rdata", rdata, 32'h0050_0093);
    chk1("t1_idle_ack_if_done", if_done, 1'b0);
    chk1("t1_idle_ack_d_done", d_done, 1'b0);
    chk1("t1_idle_ack_m_req", m_req, 1'b0);
    m_ack = 1'b0;

    // 2: both request in the first cycle after reset; data first
    rst = 1'b0;
    step();
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_addr  = 32'h300;
    d_we    = 1'b0;
    step();
    chk32("t2_first_addr", m_addr, 32'h300);
    chk1("t2_first_we", m_we, 1'b0);
    m_ack   = 1'b1;
    m_rdata = 32'h1111_1111;
    step();
    chk1("t2_d_done", d_done, 1'b1);
    chk1("t2_if_done_not_yet", if_done, 1'b0);
    chk32("t2_rdata_d", rdata, 32'h1111_1111);
    d_req = 1'b0;
    m_ack = 1'b0;
    step();
    chk1("t2_idle_m_req", m_req, 1'b0);
    step();
    chk1("t2_second_m_req", m_req, 1'b1);
    chk32("t2_second_addr", m_addr, 32'h200);
    m_ack   = 1'b1;
    m_rdata = 32'h2222_2222;
    step();
    chk1("t2_if_done", if_done, 1'b1);
    chk1("t2_d_done_clear", d_done, 1'b0);
    chk32("t2_rdata_if", rdata, 32'h2222_2222);
    if_req = 1'b0;
    m_ack  = 1'b0;
    step();

    // 3: both held, one wait state each, alternate D, IF, D, IF
    if_req = 1'b1;
    d_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      own_d = (i % 2) == 0;
      step();
      chk1("t3_m_req", m_req, 1'b1);
      chk32("t3_m_addr", m_addr, own_d ? 32'h300 : 32'h200);
      step();
      chk1("t3_wait_m_req", m_req, 1'b1);
      chk1("t3_wait_d_done", d_done, 1'b0);
      chk1("t3_wait_if_done", if_done, 1'b0);
      m_ack   = 1'b1;
      m_rdata = 32'ha000_0000 + 32'(i);
      step();
      chk1("t3_d_done", d_done, own_d);
      chk1("t3_if_done", if_done, !own_d);
      chk32("t3_rdata", rdata, 32'ha000_0000 + 32'(i));
      m_ack = 1'b0;
      step();
      chk1("t3_d_done_width", d_done, 1'b0);
      chk1("t3_if_done_width", if_done, 1'b0);
    end
    if_req    = 1'b0;
    d_req     = 1'b0;
    exp_rdata = 32'ha000_0003;
    step();

    // 4: store with ack after 3 wait cycles
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'hdead_beef;
    d_be    = 4'b0011;
    step();
    for (int i = 0; i < 3; i++) begin
      chk1("t4_m_req", m_req, 1'b1);
      chk1("t4_m_we", m_we, 1'b1);
      chk32("t4_m_addr", m_addr, 32'h40);
      chk32("t4_m_wdata", m_wdata, 32'hdead_beef);
      chk32("t4_m_be", 32'(m_be), 32'h3);
      chk1("t4_d_done_early", d_done, 1'b0);
      step();
    end
    chk1("t4_m_req_ack_cycle", m_req, 1'b1);
    m_ack   = 1'b1;
    m_rdata = 32'h1234_5678;
    step();
    chk1("t4_d_done", d_done, 1'b1);
    chk32("t4_rdata_kept", rdata, exp_rdata);
    chk1("t4_m_req_drop", m_req, 1'b0);
    chk1("t4_bus_error", bus_error, 1'b0);
    d_req = 1'b0;
    d_we  = 1'b0;
    m_ack = 1'b0;
    step();

    // 5: load that is never acknowledged; abort after 8 busy cycles
    d_req  = 1'b1;
    d_addr = 32'h80;
    step();
    for (int i = 0; i < 8; i++) begin
      chk1("t5_m_req_busy", m_req, 1'b1);
      chk1("t5_d_done_busy", d_done, 1'b0);
      chk1("t5_bus_error_busy", bus_error, 1'b0);
      step();
    end
    chk1("t5_m_req_drop", m_req, 1'b0);
    chk1("t5_d_done", d_done, 1'b1);
    chk32("t5_rdata_zero", rdata, 32'h0);
    chk1("t5_bus_error", bus_error, 1'b1);
    d_req = 1'b0;
    step();
    chk1("t5_d_done_width", d_done, 1'b0);
    step();
    chk1("t5_bus_error_sticky", bus_error, 1'b1);

    // 6: reset in the middle of a fetch
    if_req  = 1'b1;
    if_addr = 32'h500;
    step();
    chk1("t6_m_req_busy", m_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("t6_m_req_async", m_req, 1'b0);
    chk1("t6_bus_error_async", bus_error, 1'b0);
    chk1("t6_if_done_async", if_done, 1'b0);
    if_req = 1'b0;
    step();
    chk1("t6_if_done_none", if_done, 1'b0);
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h600;
    d_req   = 1'b1;
    d_addr  = 32'h700;
    step();
    chk32("t6_grant_data_addr", m_addr, 32'h700);
    m_ack   = 1'b1;
    m_rdata = 32'h3333_3333;
    step();
    chk1("t6_d_done", d_done, 1'b1);
    chk1("t6_if_done", if_done, 1'b0);
    if_req = 1'b0;
    d_req  = 1'b0;
    m_ack  = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
